// File: rtl/booth_mult_arbiter_pkg.sv
// Shared definitions for the booth multiplier arbiter: FSM encoding,
// default sizing and a small one-hot helper.
package booth_mult_arbiter_pkg;

  localparam int DEF_WIDTH   = 4;
  localparam int DEF_LATENCY = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic [1:0] onehot2(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/booth_mult_arbiter_rr.sv
// Two-way round-robin grant: on a tie the requester that was not served
// last wins; a lone requester always wins.
module rr_arbiter2
  import booth_mult_arbiter_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last,
  output logic [1:0] grant,
  output logic       owner
);

  always_comb begin
    owner = valid[1] & (~valid[0] | ~last);
    grant = (valid == 2'b00) ? 2'b00 : onehot2(owner);
  end

endmodule

// File: rtl/booth_mult_arbiter.sv
// Shares one sequential booth multiplier between two requesters: arbitrate,
// pulse the multiplier load, wait a fixed run time, then hand back the product.
module booth_mult_arbiter
  import booth_mult_arbiter_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req0_valid,
  input  logic                 req1_valid,
  output logic                 req0_ready,
  output logic                 req1_ready,
  input  logic [WIDTH-1:0]     req0_a,
  input  logic [WIDTH-1:0]     req0_b,
  input  logic [WIDTH-1:0]     req1_a,
  input  logic [WIDTH-1:0]     req1_b,
  output logic [1:0]           resp_valid,
  input  logic [1:0]           resp_ready,
  output logic [2*WIDTH-1:0]   resp_product,
  output logic                 busy,
  output logic [WIDTH-1:0]     mul_multiplicand,
  output logic [WIDTH-1:0]     mul_multiplier,
  output logic                 mul_load,
  input  logic [2*WIDTH-1:0]   mul_product
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t          state, nxt;
  logic            last, owner_q;
  logic [CW-1:0]   cnt;
  logic [1:0]      grant;
  logic            gnt_id;
  logic            idle_ok, accept, run_end;

  rr_arbiter2 u_arb (
    .valid ({req1_valid, req0_valid}),
    .last  (last),
    .grant (grant),
    .owner (gnt_id)
  );

  // ready is suppressed while reset is held so nothing is granted out of reset
  assign idle_ok    = (state == IDLE) && !reset;
  assign req0_ready = idle_ok & grant[0];
  assign req1_ready = idle_ok & grant[1];
  assign accept     = idle_ok & (|grant);
  assign run_end    = (state == RUN) && (cnt == CW'(LATENCY-1));

  assign mul_load   = (state == LOAD);
  assign busy       = (state != IDLE);
  assign resp_valid = (state == DONE) ? onehot2(owner_q) : 2'b00;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (accept)              nxt = LOAD;
      LOAD:                          nxt = RUN;
      RUN:  if (run_end)             nxt = DONE;
      DONE: if (resp_ready[owner_q]) nxt = IDLE;
      default:                       nxt = IDLE;
    endcase
  end

  // Operands stay on the multiplier inputs until the next accept.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last             <= 1'b1;
      owner_q          <= 1'b0;
      cnt              <= '0;
      mul_multiplicand <= '0;
      mul_multiplier   <= '0;
      resp_product     <= '0;
    end else begin
      if (accept) begin
        mul_multiplicand <= gnt_id ? req1_a : req0_a;
        mul_multiplier   <= gnt_id ? req1_b : req0_b;
        owner_q          <= gnt_id;
        last             <= gnt_id;
      end
      if (state == LOAD)     cnt <= '0;
      else if (state == RUN) cnt <= cnt + 1'b1;
      if (run_end)           resp_product <= mul_product;
    end
  end

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Bench for booth_mult_arbiter: a behavioural sequential multiplier on the
// mul_* side, a table of request vectors, and hand sequences for stalls/reset.
module tb_booth_mult_arbiter;

  localparam int W   = 4;
  localparam int W2  = 2 * W;
  localparam int LAT = 4;

  logic          clock, reset;
  logic          req0_valid, req1_valid, req0_ready, req1_ready;
  logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
  logic [1:0]    resp_valid, resp_ready;
  logic [W2-1:0] resp_product, mul_product;
  logic          busy, mul_load;
  logic [W-1:0]  mul_multiplicand, mul_multiplier;

  booth_mult_arbiter #(.WIDTH(W), .LATENCY(LAT)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_product(resp_product),
    .busy(busy), .mul_multiplicand(mul_multiplicand), .mul_multiplier(mul_multiplier),
    .mul_load(mul_load), .mul_product(mul_product)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Multiplier model: product appears LAT-1 edges after the load edge,
  // junk before that so an early capture is visible.
  logic signed [W2-1:0] mprod;
  int mcnt;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mcnt  <= 0;
      mprod <= '0;
    end else if (mul_load) begin
      mprod <= $signed({{W{mul_multiplicand[W-1]}}, mul_multiplicand}) *
               $signed({{W{mul_multiplier[W-1]}}, mul_multiplier});
      mcnt  <= 0;
    end else if (mcnt < 15) begin
      mcnt <= mcnt + 1;
    end
  end
  assign mul_product = (mcnt >= LAT-1) ? mprod : 8'hA5;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] oh(input logic o);
    return o ? 2'b10 : 2'b01;
  endfunction

  typedef struct {
    logic          owner;
    logic [W2-1:0] p;
    logic [W-1:0]  a, b;
    int            acc;
  } sb_t;
  sb_t q[$];

  logic [W2-1:0] exp_p [2];
  int   first_owner;
  logic prev_rv, prev_ld;

  // Scoreboard: push on accept, compare while a response is shown, pop on handshake.
  always @(negedge clock) begin
    if (reset) begin
      q.delete();
      prev_rv = 1'b0;
      prev_ld = 1'b0;
    end else begin
      chk("busy", busy, q.size() != 0);
      chk("one_ready", req0_ready & req1_ready, 0);
      if (mul_load) begin
        chk("load_pending", q.size() != 0, 1);
        chk("load_one_cycle", prev_ld, 0);
        if (q.size() != 0) begin
          chk("load_time", cyc - q[0].acc, 1);
          chk("mul_a", mul_multiplicand, q[0].a);
          chk("mul_b", mul_multiplier, q[0].b);
        end
      end
      if (resp_valid != 2'b00) begin
        chk("resp_pending", q.size() != 0, 1);
        if (q.size() != 0) begin
          if (!prev_rv) chk("latency", cyc - q[0].acc, LAT + 2);
          chk("resp_valid", resp_valid, oh(q[0].owner));
          chk("resp_product", resp_product, q[0].p);
          if (resp_ready[q[0].owner]) void'(q.pop_front());
        end
      end
      if (req0_valid && req0_ready) begin
        q.push_back('{1'b0, exp_p[0], req0_a, req0_b, cyc});
        if (first_owner < 0) first_owner = 0;
      end
      if (req1_valid && req1_ready) begin
        q.push_back('{1'b1, exp_p[1], req1_a, req1_b, cyc});
        if (first_owner < 0) first_owner = 1;
      end
      prev_rv = (resp_valid != 2'b00);
      prev_ld = mul_load;
    end
  end

  typedef struct {
    logic v0; logic [W-1:0] a0, b0;
    logic v1; logic [W-1:0] a1, b1;
    logic [W2-1:0] p0, p1;
    int first;
  } vec_t;
  vec_t tbl [7];

  task automatic run_vec(input vec_t v);
    logic a0, a1, done;
    exp_p[0] = v.p0; exp_p[1] = v.p1; first_owner = -1;
    req0_a = v.a0; req0_b = v.b0; req0_valid = v.v0;
    req1_a = v.a1; req1_b = v.b1; req1_valid = v.v1;
    done = 1'b0;
    for (int n = 0; n < 80 && !done; n++) begin
      @(negedge clock);
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      @(posedge clock); #1;
      if (a0) req0_valid = 1'b0;
      if (a1) req1_valid = 1'b0;
      done = !req0_valid && !req1_valid && !busy && (q.size() == 0);
    end
    chk("vec_done", done, 1);
    chk("first_owner", first_owner, v.first);
  endtask

  task automatic wait_accept(input logic own, output logic ok);
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clock);
      ok = own ? req1_ready : req0_ready;
      @(posedge clock); #1;
    end
    chk("accept_seen", ok, 1);
    if (own) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      @(posedge clock); #1;
      done = !busy && (q.size() == 0);
    end
    chk("idle_reached", done, 1);
  endtask

  // Hold the owner's resp_ready low (with rr on the other bit) for nhold cycles.
  task automatic hold_seq(input logic own, input logic [W-1:0] a, b,
                          input logic [W2-1:0] p, input logic [1:0] rr, input int nhold);
    logic ok;
    resp_ready = rr;
    exp_p[own] = p;
    if (own) begin req1_a = a; req1_b = b; req1_valid = 1'b1; end
    else     begin req0_a = a; req0_b = b; req0_valid = 1'b1; end
    wait_accept(own, ok);
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clock);
      ok = (resp_valid != 2'b00);
    end
    chk("hold_resp_seen", ok, 1);
    for (int i = 0; i < nhold; i++) begin
      chk("hold_valid", resp_valid, oh(own));
      chk("hold_product", resp_product, p);
      @(negedge clock);
    end
    @(posedge clock); #1;
    resp_ready = rr | oh(own);
    @(negedge clock);
    @(posedge clock); #1;
    chk("hold_exit_idle", busy, 0);
    resp_ready = 2'b11;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired t=%0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    tbl[0] = '{1'b1, 4'd2, 4'd3, 1'b1, 4'hD, 4'd5, 8'h06, 8'hF1, 0};
    tbl[1] = '{1'b1, 4'd3, 4'd2, 1'b0, 4'd0, 4'd0, 8'h06, 8'h00, 0};
    tbl[2] = '{1'b0, 4'd0, 4'd0, 1'b1, 4'd7, 4'd7, 8'h00, 8'h31, 1};
    tbl[3] = '{1'b1, 4'h8, 4'h8, 1'b1, 4'd7, 4'h8, 8'h40, 8'hC8, 0};
    tbl[4] = '{1'b1, 4'hF, 4'hF, 1'b1, 4'd0, 4'd5, 8'h01, 8'h00, 0};
    tbl[5] = '{1'b1, 4'h8, 4'd7, 1'b0, 4'd0, 4'd0, 8'hC8, 8'h00, 0};
    tbl[6] = '{1'b1, 4'd5, 4'd5, 1'b1, 4'hE, 4'd3, 8'h19, 8'hFA, 1};

    first_owner = -1;
    exp_p[0] = '0; exp_p[1] = '0;
    reset = 1'b1; resp_ready = 2'b11;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (3) @(posedge clock); #1;
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_req1_ready", req1_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_product", resp_product, 0);
    chk("rst_mul_load", mul_load, 0);
    chk("rst_mul_a", mul_multiplicand, 0);
    chk("rst_mul_b", mul_multiplier, 0);
    chk("rst_busy", busy, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;

    for (int i = 0; i < 7; i++) run_vec(tbl[i]);

    // Owner stalls its resp_ready while the other bit is high.
    hold_seq(1'b1, 4'd7, 4'd7, 8'h31, 2'b01, 3);
    hold_seq(1'b0, 4'd3, 4'd2, 8'h06, 2'b10, 2);

    // Requester 1 arrives while requester 0 is running.
    exp_p[0] = 8'h06;
    req0_a = 4'd2; req0_b = 4'd3; req0_valid = 1'b1;
    wait_accept(1'b0, ok);
    repeat (3) @(posedge clock); #1;
    exp_p[1] = 8'hC8;
    req1_a = 4'd7; req1_b = 4'h8; req1_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 30 && !ok; n++) begin
      @(negedge clock);
      if (busy) chk("req1_blocked", req1_ready, 0);
      else begin
        chk("req1_first_idle", req1_ready, 1);
        ok = 1'b1;
      end
    end
    chk("late_req_idle", ok, 1);
    @(posedge clock); #1;
    req1_valid = 1'b0;
    wait_idle();

    // Reset in the middle of RUN.
    exp_p[0] = 8'h09;
    req0_a = 4'd3; req0_b = 4'd3; req0_valid = 1'b1;
    wait_accept(1'b0, ok);
    repeat (2) @(posedge clock); #1;
    chk("pre_rst_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_resp_valid", resp_valid, 0);
    chk("mid_rst_resp_product", resp_product, 0);
    chk("mid_rst_mul_load", mul_load, 0);
    chk("mid_rst_mul_a", mul_multiplicand, 0);
    chk("mid_rst_mul_b", mul_multiplier, 0);
    @(negedge clock);
    @(posedge clock); #1;
    reset = 1'b0;
    run_vec('{1'b1, 4'h8, 4'h8, 1'b0, 4'd0, 4'd0, 8'h40, 8'h00, 0});

    repeat (3) @(posedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
